// File: rtl/cacheline_adapter_pkg.sv
// Shared types and sizing for the cache-line <-> burst-bus adapter.
// The line is fixed at four 64-bit beats; the beat index width follows from that.
package cacheline_adapter_pkg;

  localparam int LINE_W_DEF  = 256;
  localparam int BURST_W_DEF = 64;
  localparam int BURST_N     = LINE_W_DEF / BURST_W_DEF;
  localparam int BEAT_W      = $clog2(BURST_N);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    READ_DONE,
    WRITE,
    WRITE_DONE
  } adapter_state_t;

  // Memory bursts always start on a 32-byte line boundary.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & ~32'h0000_001F;
  endfunction

endpackage

// File: rtl/cacheline_adapter.sv
// Bridges the cache's 256-bit line port to a 64-bit burst memory bus: a fill
// collects four beats into one line, a writeback serialises one line into four beats.
module cacheline_adapter
  import cacheline_adapter_pkg::*;
#(
  parameter int LINE_W  = LINE_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        line_addr,
  input  logic               line_read,
  input  logic               line_write,
  input  logic [LINE_W-1:0]  line_wdata,
  output logic [LINE_W-1:0]  line_rdata,
  output logic               line_resp,
  output logic [31:0]        burst_addr,
  output logic               burst_read,
  output logic               burst_write,
  output logic [BURST_W-1:0] burst_wdata,
  input  logic [BURST_W-1:0] burst_rdata,
  input  logic               burst_resp
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_N - 1);

  adapter_state_t      state_q, state_d;
  logic [BEAT_W-1:0]   cnt_q, cnt_d;
  logic [LINE_W-1:0]   buf_q, buf_d;
  logic [31:0]         addr_q, addr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        // Writeback wins so a dirty victim leaves before its replacement arrives.
        if (line_write) begin
          addr_d  = line_align(line_addr);
          buf_d   = line_wdata;
          cnt_d   = '0;
          state_d = WRITE;
        end else if (line_read) begin
          addr_d  = line_align(line_addr);
          cnt_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        if (burst_resp) begin
          for (int i = 0; i < BURST_N; i++) begin
            if (cnt_q == BEAT_W'(i)) buf_d[i*BURST_W +: BURST_W] = burst_rdata;
          end
          cnt_d = cnt_q + BEAT_W'(1);
          if (cnt_q == LAST_BEAT) state_d = READ_DONE;
        end
      end
      WRITE: begin
        if (burst_resp) begin
          cnt_d = cnt_q + BEAT_W'(1);
          if (cnt_q == LAST_BEAT) state_d = WRITE_DONE;
        end
      end
      READ_DONE:  state_d = IDLE;
      WRITE_DONE: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Everything visible to the cache and the bus decodes from registered state only.
  always_comb begin
    burst_wdata = '0;
    for (int i = 0; i < BURST_N; i++) begin
      if (cnt_q == BEAT_W'(i)) burst_wdata = buf_q[i*BURST_W +: BURST_W];
    end
  end

  assign burst_read  = (state_q == READ);
  assign burst_write = (state_q == WRITE);
  assign line_resp   = (state_q == READ_DONE) || (state_q == WRITE_DONE);
  assign line_rdata  = buf_q;
  assign burst_addr  = addr_q;

endmodule
